// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module : seg_pkg
// Brief  : Shared types and helpers for the seven-segment scan controller.
// Rev    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] DIGIT_OFF  = 4'b1111;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  function automatic logic [3:0] nibble_sel(input logic [15:0] value,
                                            input logic [1:0]  idx);
    return value[{idx, 2'b00} +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_lz_mask.sv
`default_nettype none
// ============================================================================
// Module : seg_lz_mask
// Brief  : Leading-zero suppress mask for an N-digit hex display; digit 0 is
//          never suppressed.
// Rev    : 1.0 - initial release
// ============================================================================
module seg_lz_mask
  import seg_pkg::*;
#(
  parameter int N_DIG = NUM_DIGITS
) (
  input  logic [4*N_DIG-1:0] value,
  input  logic               lz_en,
  output logic [N_DIG-1:0]   mask
);

  // w_zero_chain[i]: suppression enabled and digits N_DIG-1..i are all zero
  logic [N_DIG:1] w_zero_chain;
  logic           w_unused_low;

  assign w_zero_chain[N_DIG] = lz_en;
  assign w_unused_low        = ^value[3:0];
  assign mask[0]             = 1'b0;

  for (genvar i = N_DIG - 1; i >= 1; i--) begin : g_digit
    if (i == N_DIG - 1) begin : g_top
      assign mask[i] = lz_en & (value[4*i +: 4] == 4'h0);
    end else begin : g_lower
      assign mask[i] = w_zero_chain[i+1] & (value[4*i +: 4] == 4'h0);
    end
    assign w_zero_chain[i] = mask[i];
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : seg_scan_ctrl
// Brief  : 4-digit multiplexed seven-segment scan controller with blanking
//          gap, frame-synchronous updates and leading-zero suppression.
// Rev    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] VALUE,
  input  logic        LOAD,
  input  logic [3:0]  DP_IN,
  input  logic        LZ_EN,
  output logic [3:0]  D,
  output logic        DP,
  output logic [3:0]  DIGIT,
  output logic        FRAME_DONE,
  output logic        BUSY_PEND
);

  localparam int               CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  if (BLANK_CYC < 1 || SCAN_DIV < BLANK_CYC + 1) begin : g_param_check
    $error("seg_scan_ctrl: need BLANK_CYC >= 1 and SCAN_DIV >= BLANK_CYC+1");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  scan_state_e      state_q, state_d;
  logic [15:0]      act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [3:0]       act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic             act_lz_q, act_lz_d, pend_lz_q, pend_lz_d;
  logic             busy_q, busy_d;
  logic [3:0]       d_q, d_d;
  logic             dp_q, dp_d;
  logic [3:0]       digit_q, digit_d;
  logic             frame_done_q, frame_done_d;

  logic             w_slot_end;
  logic             w_boundary;
  logic [3:0]       w_lz_mask;

  always_comb begin
    w_slot_end = (cnt_q == CNT_LAST);
    w_boundary = w_slot_end && (idx_q == 2'(NUM_DIGITS - 1));
    cnt_d      = w_slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d      = w_slot_end ? idx_q + 2'd1 : idx_q;

    state_d = state_q;
    if (state_q == ST_BLANK && cnt_q == BLANK_LAST) begin
      state_d = ST_DRIVE;
    end else if (w_slot_end) begin
      state_d = ST_BLANK;
    end

    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    act_lz_d   = act_lz_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_lz_d  = pend_lz_q;
    busy_d     = busy_q;

    if (w_boundary && busy_q) begin
      act_val_d = pend_val_q;
      act_dp_d  = pend_dp_q;
      act_lz_d  = pend_lz_q;
      busy_d    = 1'b0;
    end
    // A load on the boundary cycle lands in pending and waits a full frame.
    if (LOAD) begin
      pend_val_d = VALUE;
      pend_dp_d  = DP_IN;
      pend_lz_d  = LZ_EN;
      busy_d     = 1'b1;
    end

    frame_done_d = w_boundary;
  end

  seg_lz_mask #(
    .N_DIG (NUM_DIGITS)
  ) u_lz_mask (
    .value (act_val_d),
    .lz_en (act_lz_d),
    .mask  (w_lz_mask)
  );

  // D/DP are loaded on entry to a slot so the decoder settles during blanking.
  always_comb begin
    d_d  = d_q;
    dp_d = dp_q;
    if (cnt_d == '0) begin
      d_d  = nibble_sel(act_val_d, idx_d);
      dp_d = act_dp_d[idx_d] & ~w_lz_mask[idx_d];
    end

    digit_d = DIGIT_OFF;
    if (state_d == ST_DRIVE && !w_lz_mask[idx_d]) begin
      digit_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      state_q      <= ST_BLANK;
      act_val_q    <= 16'h0000;
      act_dp_q     <= 4'h0;
      act_lz_q     <= 1'b0;
      pend_val_q   <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_lz_q    <= 1'b0;
      busy_q       <= 1'b0;
      d_q          <= 4'h0;
      dp_q         <= 1'b0;
      digit_q      <= DIGIT_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_lz_q     <= act_lz_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_lz_q    <= pend_lz_d;
      busy_q       <= busy_d;
      d_q          <= d_d;
      dp_q         <= dp_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign D          = d_q;
  assign DP         = dp_q;
  assign DIGIT      = digit_q;
  assign FRAME_DONE = frame_done_q;
  assign BUSY_PEND  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_seg_scan_ctrl
// Brief  : Directed self-checking bench for seg_scan_ctrl (SCAN_DIV=8,
//          BLANK_CYC=2, so one frame is 32 cycles).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  d;
  logic        dp;
  logic [3:0]  digit;
  logic        frame_done;
  logic        busy_pend;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  seg_scan_ctrl #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .VALUE      (value),
    .LOAD       (load),
    .DP_IN      (dp_in),
    .LZ_EN      (lz_en),
    .D          (d),
    .DP         (dp),
    .DIGIT      (digit),
    .FRAME_DONE (frame_done),
    .BUSY_PEND  (busy_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Cycle k is the interval after the k-th rising edge since reset release.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpi, input logic lz);
    value = v; dp_in = dpi; lz_en = lz; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Walks one frame from its first cycle, checking blank and drive phases per slot.
  task automatic check_frame(input string tag, input logic [15:0] ev,
                             input logic [3:0] eon, input logic [3:0] edp);
    int base;
    base = cyc;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] en;
      en = eon[i] ? ~(4'b0001 << i) : 4'hF;
      step_to(base + 8*i);
      chk({tag, "_blank_digit"}, 16'(digit), 16'hF);
      chk({tag, "_blank_d"}, 16'(d), 16'(ev[4*i +: 4]));
      chk({tag, "_blank_dp"}, 16'(dp), 16'(edp[i]));
      step_to(base + 8*i + 2);
      chk({tag, "_drive_digit"}, 16'(digit), 16'(en));
      chk({tag, "_drive_d"}, 16'(d), 16'(ev[4*i +: 4]));
      step_to(base + 8*i + 7);
      chk({tag, "_last_digit"}, 16'(digit), 16'(en));
    end
    step_to(base + 32);
  endtask

  initial begin
    logic [3:0] exp_dig;
    rst_n = 1'b0; value = 16'h0; load = 1'b0; dp_in = 4'h0; lz_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    chk("rst_d", 16'(d), 16'h0);
    chk("rst_dp", 16'(dp), 16'h0);
    chk("rst_digit", 16'(digit), 16'hF);
    chk("rst_frame_done", 16'(frame_done), 16'h0);
    chk("rst_busy", 16'(busy_pend), 16'h0);

    // Idle scan: 2 blank + 6 drive per slot, FRAME_DONE at every frame start.
    for (int k = 0; k < 64; k++) begin
      step_to(k);
      exp_dig = ((k % 8) < 2) ? 4'hF : ~(4'b0001 << ((k / 8) % 4));
      chk("idle_digit", 16'(digit), 16'(exp_dig));
      chk("idle_d", 16'(d), 16'h0);
      chk("idle_frame_done", 16'(frame_done), 16'((k % 32 == 0) && (k != 0)));
      chk("idle_busy", 16'(busy_pend), 16'h0);
    end
    step_to(64);
    chk("idle_frame_done_64", 16'(frame_done), 16'h1);

    // Mid-frame load waits for the boundary.
    step_to(69);
    do_load(16'h1A3F, 4'h0, 1'b0);
    chk("ld1_busy", 16'(busy_pend), 16'h1);
    step_to(95);
    chk("ld1_old_d", 16'(d), 16'h0);
    chk("ld1_busy_95", 16'(busy_pend), 16'h1);
    chk("ld1_fd_95", 16'(frame_done), 16'h0);
    step_to(96);
    chk("ld1_fd_96", 16'(frame_done), 16'h1);
    chk("ld1_busy_96", 16'(busy_pend), 16'h0);
    chk("ld1_d_96", 16'(d), 16'hF);
    check_frame("f1A3F", 16'h1A3F, 4'hF, 4'h0);

    // Two loads in one frame: the last one wins.
    step_to(130);
    do_load(16'h1234, 4'h0, 1'b0);
    step_to(140);
    do_load(16'h5678, 4'h0, 1'b0);
    step_to(156);
    chk("ld2_old_d", 16'(d), 16'h1);
    chk("ld2_busy", 16'(busy_pend), 16'h1);
    step_to(160);
    chk("ld2_busy_160", 16'(busy_pend), 16'h0);
    check_frame("f5678", 16'h5678, 4'hF, 4'h0);

    // Leading-zero suppression with DP requests on every digit.
    step_to(192);
    do_load(16'h0050, 4'hF, 1'b1);
    step_to(224);
    check_frame("lz0050", 16'h0050, 4'b0011, 4'b0011);
    do_load(16'h0000, 4'h0, 1'b1);
    step_to(288);
    check_frame("lz0000", 16'h0000, 4'b0001, 4'h0);

    // Load exactly on the boundary cycle is deferred a whole frame.
    step_to(351);
    do_load(16'hBEEF, 4'b0101, 1'b0);
    chk("bnd_fd", 16'(frame_done), 16'h1);
    chk("bnd_busy", 16'(busy_pend), 16'h1);
    chk("bnd_d", 16'(d), 16'h0);
    check_frame("bnd_old", 16'h0000, 4'b0001, 4'h0);
    chk("bnd_fd_384", 16'(frame_done), 16'h1);
    chk("bnd_busy_384", 16'(busy_pend), 16'h0);
    check_frame("fBEEF", 16'hBEEF, 4'hF, 4'b0101);

    // Asynchronous reset during DRIVE of digit 2 with a load pending.
    step_to(420);
    do_load(16'h4321, 4'hF, 1'b0);
    step_to(436);
    chk("pre_rst_digit", 16'(digit), 16'hB);
    chk("pre_rst_d", 16'(d), 16'hE);
    chk("pre_rst_dp", 16'(dp), 16'h1);
    chk("pre_rst_busy", 16'(busy_pend), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_digit", 16'(digit), 16'hF);
    chk("arst_d", 16'(d), 16'h0);
    chk("arst_dp", 16'(dp), 16'h0);
    chk("arst_busy", 16'(busy_pend), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    check_frame("post_rst", 16'h0000, 4'hF, 4'h0);
    chk("post_rst_fd", 16'(frame_done), 16'h1);
    chk("post_rst_busy", 16'(busy_pend), 16'h0);
    chk("post_rst_d", 16'(d), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
